axi4_lite_regbank: RTL

- Parametrised AXI4-Lite slave register bank. It terminates one `axi4_lite_if.s` port and exposes N_REGS registers of DW bits to fabric logic.
- Adds over a bare bus interface: independent AW/W acceptance, byte-strobe writes, per-register read-only mask, out-of-range SLVERR, hardware-side update inputs, and per-register SW access pulses.
- Sits between the AXI4-Lite interconnect and control/status logic of each IP block.

---
 rtl/axi4_lite_pkg.sv | 42 ++++
 rtl/axi4_lite_if.sv | 41 ++++
 rtl/axi4_lite_wr_collect.sv | 80 ++++++++
 rtl/axi4_lite_regbank.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite types and address/strobe helpers
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef struct packed {
      logic        ok;
      logic [31:0] idx;
   } idx_res_t;

   // Word index of a byte address relative to base; low address bits are ignored.
   function automatic idx_res_t addr_to_idx(input logic [63:0] addr,
                                            input logic [63:0] base,
                                            input int          dw,
                                            input int          n_regs);
      idx_res_t    r;
      logic [63:0] off;
      off   = addr - base;
      off   = (dw == 64) ? (off >> 3) : (off >> 2);
      r.idx = off[31:0];
      r.ok  = (addr >= base) && (off < 64'(n_regs));
      return r;
   endfunction

   // Byte-lane merge: lanes with strb set take new_val, the rest keep old_val.
   function automatic logic [63:0] apply_strb(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
      logic [63:0] r;
      r = old_val;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// rtl/axi4_lite_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi4_lite_if #(
   parameter int AW = 32,
   parameter int DW = 64
) ();
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport m (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport s (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi4_lite_wr_collect.sv
// rtl/axi4_lite_wr_collect.sv - independent AW/W capture producing a single write commit
module axi4_lite_wr_collect #(
   parameter int AW = 32,
   parameter int DW = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   awaddr_i,
   input  logic            awvalid_i,
   output logic            awready_o,
   input  logic [DW-1:0]   wdata_i,
   input  logic [DW/8-1:0] wstrb_i,
   input  logic            wvalid_i,
   output logic            wready_o,
   input  logic            bvalid_i,
   output logic            commit_o,
   output logic [AW-1:0]   addr_o,
   output logic [DW-1:0]   data_o,
   output logic [DW/8-1:0] strb_o
);
   logic            aw_held_q, aw_held_d;
   logic            w_held_q, w_held_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic [DW/8-1:0] strb_q, strb_d;
   logic            aw_hs, w_hs, aw_have, w_have;

   assign awready_o = !aw_held_q && !bvalid_i && !rst;
   assign wready_o  = !w_held_q && !bvalid_i && !rst;
   assign aw_hs     = awvalid_i && awready_o;
   assign w_hs      = wvalid_i && wready_o;
   assign aw_have   = aw_held_q || aw_hs;
   assign w_have    = w_held_q || w_hs;
   assign commit_o  = aw_have && w_have && !bvalid_i;

   // A channel handshaking at the commit edge is forwarded directly.
   assign addr_o = aw_held_q ? addr_q : awaddr_i;
   assign data_o = w_held_q ? data_q : wdata_i;
   assign strb_o = w_held_q ? strb_q : wstrb_i;

   // Capture each channel independently; both hold flags drop at commit
   always_comb begin
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      addr_d    = addr_q;
      data_d    = data_q;
      strb_d    = strb_q;
      if (aw_hs) begin
         aw_held_d = 1'b1;
         addr_d    = awaddr_i;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         data_d   = wdata_i;
         strb_d   = wstrb_i;
      end
      if (commit_o) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end
   end

   // Hold-register state update
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
      end
   end

endmodule

// File: rtl/axi4_lite_regbank.sv
// rtl/axi4_lite_regbank.sv - AXI4-Lite slave register bank with hw update and access pulses
module axi4_lite_regbank
   import axi4_lite_pkg::*;
#(
   parameter int                AW      = 32,
   parameter int                DW      = 64,
   parameter int                N_REGS  = 16,
   parameter logic [AW-1:0]     BASE    = '0,
   parameter logic [N_REGS-1:0] RO_MASK = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   axi4_lite_if.s               bus,
   output logic [N_REGS*DW-1:0] reg_o,
   output logic [N_REGS-1:0]    wr_pulse_o,
   output logic [N_REGS-1:0]    rd_pulse_o,
   input  logic [N_REGS-1:0]    hw_we_i,
   input  logic [N_REGS*DW-1:0] hw_wdata_i
);
   logic [DW-1:0]     regs_q [N_REGS];
   logic [DW-1:0]     regs_d [N_REGS];
   logic              bvalid_q, bvalid_d;
   resp_t             bresp_q, bresp_d;
   logic              rvalid_q, rvalid_d;
   resp_t             rresp_q, rresp_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [N_REGS-1:0] wr_pulse_q, wr_pulse_d;
   logic [N_REGS-1:0] rd_pulse_q, rd_pulse_d;

   logic              commit;
   logic [AW-1:0]     c_addr;
   logic [DW-1:0]     c_data;
   logic [DW/8-1:0]   c_strb;
   idx_res_t          w_res, r_res;
   logic [N_REGS-1:0] w_hit, w_hit_rw, r_hit;
   logic [63:0]       merged;
   logic              ar_hs;
   logic              prot_unused;

   axi4_lite_wr_collect #(
      .AW (AW),
      .DW (DW)
   ) u_wr_collect (
      .clk       (clk),
      .rst       (rst),
      .awaddr_i  (bus.awaddr),
      .awvalid_i (bus.awvalid),
      .awready_o (bus.awready),
      .wdata_i   (bus.wdata),
      .wstrb_i   (bus.wstrb),
      .wvalid_i  (bus.wvalid),
      .wready_o  (bus.wready),
      .bvalid_i  (bvalid_q),
      .commit_o  (commit),
      .addr_o    (c_addr),
      .data_o    (c_data),
      .strb_o    (c_strb)
   );

   assign prot_unused = ^{bus.awprot, bus.arprot};

   assign w_res   = addr_to_idx(64'(c_addr), 64'(BASE), DW, N_REGS);
   assign r_res   = addr_to_idx(64'(bus.araddr), 64'(BASE), DW, N_REGS);
   assign bus.arready = !rvalid_q && !rst;
   assign ar_hs   = bus.arvalid && bus.arready;

   assign bus.bvalid = bvalid_q;
   assign bus.bresp  = bresp_q;
   assign bus.rvalid = rvalid_q;
   assign bus.rresp  = rresp_q;
   assign bus.rdata  = rdata_q;
   assign wr_pulse_o = wr_pulse_q;
   assign rd_pulse_o = rd_pulse_q;

   for (genvar g = 0; g < N_REGS; g++) begin : g_reg_out
      assign reg_o[g*DW +: DW] = regs_q[g];
   end

   // Register next state: hw load first, then strobed SW bytes override it
   always_comb begin
      merged = '0;
      w_hit  = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (commit && w_res.ok && (w_res.idx == 32'(i))) w_hit[i] = 1'b1;
      end
      w_hit_rw = w_hit & ~RO_MASK;
      for (int i = 0; i < N_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (hw_we_i[i]) regs_d[i] = hw_wdata_i[i*DW +: DW];
         if (w_hit_rw[i]) begin
            merged    = apply_strb(64'(regs_d[i]), 64'(c_data), 8'(c_strb));
            regs_d[i] = merged[DW-1:0];
         end
      end
   end

   // Write response: raised by a commit, dropped by the B handshake
   always_comb begin
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = w_hit_rw;
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = (|w_hit_rw) ? OKAY : SLVERR;
      end else if (bvalid_q && bus.bready) begin
         bvalid_d = 1'b0;
      end
   end

   // Read response: sampled from pre-update register contents at AR handshake
   always_comb begin
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      r_hit    = '0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = r_res.ok ? OKAY : SLVERR;
         for (int i = 0; i < N_REGS; i++) begin
            if (r_res.ok && (r_res.idx == 32'(i))) begin
               r_hit[i] = 1'b1;
               rdata_d  = regs_q[i];
            end
         end
      end else if (rvalid_q && bus.rready) begin
         rvalid_d = 1'b0;
      end
      rd_pulse_d = r_hit;
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= OKAY;
         rvalid_q   <= 1'b0;
         rresp_q    <= OKAY;
         rdata_q    <= '0;
         wr_pulse_q <= '0;
         rd_pulse_q <= '0;
      end else begin
         for (int i = 0; i < N_REGS; i++) regs_q[i] <= regs_d[i];
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         wr_pulse_q <= wr_pulse_d;
         rd_pulse_q <= rd_pulse_d;
      end
   end

endmodule
